uarc_receiver_front: RTL

- Receiving end of the UARC inter-core bus: takes the per-bus kill/incept/send/stream requests that remote senders drive, arbitrates among them and returns the matching one-cycle acks.
- Queues accepted incept/send/stream events in an internal FIFO for core consumption; kills bypass the FIFO.
- Sits between the receiver_* bus bundle and the core's event-dispatch logic.

---
 rtl/uarc_pkg.sv | 23 ++
 rtl/uarc_event_fifo.sv | 69 ++++++
 rtl/uarc_receiver_front.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uarc_pkg.sv
// Shared types for the UARC receiver front end: event kinds and kind selection.
package uarc_pkg;

    localparam int EV_KIND_WIDTH = 2;

    typedef enum logic [EV_KIND_WIDTH-1:0] {
        EV_INCEPT = 2'd0,
        EV_SEND   = 2'd1,
        EV_STREAM = 2'd2
    } ev_kind_e;

    // Non-kill request priority on one bus: incept > send > stream.
    function automatic ev_kind_e pick_kind(input logic incept, input logic send);
        if (incept) begin
            return EV_INCEPT;
        end
        if (send) begin
            return EV_SEND;
        end
        return EV_STREAM;
    endfunction

endpackage

// File: rtl/uarc_event_fifo.sv
// Event FIFO: power-of-two depth, wrap-bit pointers, flush clears occupancy.
module uarc_event_fifo #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_data,
    output logic                  valid,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    logic [ADDR_WIDTH:0] wr_q, wr_d;
    logic [ADDR_WIDTH:0] rd_q, rd_d;
    logic                do_push;
    logic                do_pop;

    // Status, head read and pointer/storage next-state; a flush wins over push and pop.
    always_comb begin
        count     = wr_q - rd_q;
        valid     = (wr_q != rd_q);
        full      = (count == FULL_COUNT);
        head_data = mem_q[rd_q[ADDR_WIDTH-1:0]];
        do_pop    = pop & valid;
        do_push   = push & (~full | do_pop);
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q[ADDR_WIDTH-1:0]] = push_data;
                wr_d = wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_d = rd_q + 1'b1;
            end
        end
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uarc_receiver_front.sv
// UARC receiver front end: round-robin request arbitration, registered acks,
// kill pulse to the core and an event FIFO for incept/send/stream traffic.
module uarc_receiver_front
    import uarc_pkg::*;
#(
    parameter int  WORD_MAG        = 5,
    parameter int  TOTAL_BUSES     = 1,
    parameter int  FIFO_ADDR_WIDTH = 2,
    localparam int WORD_WIDTH      = 1 << WORD_MAG,
    localparam int BUS_IDX_WIDTH   = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [TOTAL_BUSES-1:0]                receiver_enables,
    input  logic [TOTAL_BUSES-1:0]                receiver_kills,
    output logic [TOTAL_BUSES-1:0]                receiver_kill_acks,
    input  logic [TOTAL_BUSES-1:0]                receiver_incepts,
    output logic [TOTAL_BUSES-1:0]                receiver_incept_acks,
    input  logic [TOTAL_BUSES-1:0]                receiver_sends,
    output logic [TOTAL_BUSES-1:0]                receiver_send_acks,
    input  logic [TOTAL_BUSES-1:0]                receiver_streams,
    output logic [TOTAL_BUSES-1:0]                receiver_stream_acks,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_datas,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_incept_permissions,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_incept_addresses,
    output logic                                  kill_out,
    output logic [BUS_IDX_WIDTH-1:0]              kill_bus,
    output logic                                  event_valid,
    input  logic                                  event_ready,
    output logic [EV_KIND_WIDTH-1:0]              event_kind,
    output logic [BUS_IDX_WIDTH-1:0]              event_bus,
    output logic [WORD_WIDTH-1:0]                 event_data,
    output logic [WORD_WIDTH-1:0]                 event_permission,
    output logic [WORD_WIDTH-1:0]                 event_address,
    output logic [FIFO_ADDR_WIDTH:0]              fifo_count
);

    typedef struct packed {
        ev_kind_e                 kind;
        logic [BUS_IDX_WIDTH-1:0] bus;
        logic [WORD_WIDTH-1:0]    data;
        logic [WORD_WIDTH-1:0]    permission;
        logic [WORD_WIDTH-1:0]    address;
    } event_t;

    logic [TOTAL_BUSES-1:0]   kill_ack_q, kill_ack_d;
    logic [TOTAL_BUSES-1:0]   incept_ack_q, incept_ack_d;
    logic [TOTAL_BUSES-1:0]   send_ack_q, send_ack_d;
    logic [TOTAL_BUSES-1:0]   stream_ack_q, stream_ack_d;
    logic                     kill_out_q, kill_out_d;
    logic [BUS_IDX_WIDTH-1:0] kill_bus_q, kill_bus_d;
    logic [BUS_IDX_WIDTH-1:0] ptr_q, ptr_d;

    logic [TOTAL_BUSES-1:0]   ack_busy;
    logic [TOTAL_BUSES-1:0]   kill_req;
    logic [TOTAL_BUSES-1:0]   norm_req;
    logic [TOTAL_BUSES-1:0]   arb_req;
    logic                     kill_sel;
    logic                     can_push;
    logic                     grant;
    logic [BUS_IDX_WIDTH-1:0] grant_idx;
    logic [BUS_IDX_WIDTH-1:0] cand;

    logic                     fifo_push;
    logic                     fifo_flush;
    logic                     fifo_full;
    event_t                   ev_in;
    event_t                   ev_head;

    // Round-robin pick; a bus still seeing its ack is masked so a held request is not granted twice.
    always_comb begin
        ack_busy  = kill_ack_q | incept_ack_q | send_ack_q | stream_ack_q;
        kill_req  = receiver_enables & receiver_kills & ~ack_busy;
        norm_req  = receiver_enables & ~receiver_kills & ~ack_busy &
                    (receiver_incepts | receiver_sends | receiver_streams);
        can_push  = ~fifo_full | (event_ready & event_valid);
        kill_sel  = |kill_req;
        arb_req   = kill_sel ? kill_req : (can_push ? norm_req : '0);
        grant     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int off = 0; off < TOTAL_BUSES; off++) begin
            cand = BUS_IDX_WIDTH'((int'(ptr_q) + off) % TOTAL_BUSES);
            if (!grant && arb_req[cand]) begin
                grant     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Turn the grant into next-cycle acks, a kill pulse with flush, or a FIFO push.
    always_comb begin
        kill_ack_d     = '0;
        incept_ack_d   = '0;
        send_ack_d     = '0;
        stream_ack_d   = '0;
        kill_out_d     = 1'b0;
        kill_bus_d     = kill_bus_q;
        ptr_d          = ptr_q;
        fifo_push      = 1'b0;
        fifo_flush     = 1'b0;
        ev_in          = '0;
        ev_in.bus      = grant_idx;
        ev_in.data     = receiver_datas[grant_idx];
        ev_in.kind     = pick_kind(receiver_incepts[grant_idx], receiver_sends[grant_idx]);
        if (ev_in.kind == EV_INCEPT) begin
            ev_in.permission = receiver_incept_permissions[grant_idx];
            ev_in.address    = receiver_incept_addresses[grant_idx];
        end
        if (grant) begin
            ptr_d = BUS_IDX_WIDTH'((int'(grant_idx) + 1) % TOTAL_BUSES);
            if (kill_sel) begin
                kill_ack_d[grant_idx] = 1'b1;
                kill_out_d            = 1'b1;
                kill_bus_d            = grant_idx;
                fifo_flush            = 1'b1;
            end else begin
                fifo_push = 1'b1;
                case (ev_in.kind)
                    EV_INCEPT: incept_ack_d[grant_idx] = 1'b1;
                    EV_SEND:   send_ack_d[grant_idx]   = 1'b1;
                    default:   stream_ack_d[grant_idx] = 1'b1;
                endcase
            end
        end
    end

    // Ack, kill and pointer registers; reset drops any ack in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            kill_ack_q   <= '0;
            incept_ack_q <= '0;
            send_ack_q   <= '0;
            stream_ack_q <= '0;
            kill_out_q   <= 1'b0;
            kill_bus_q   <= '0;
            ptr_q        <= '0;
        end else begin
            kill_ack_q   <= kill_ack_d;
            incept_ack_q <= incept_ack_d;
            send_ack_q   <= send_ack_d;
            stream_ack_q <= stream_ack_d;
            kill_out_q   <= kill_out_d;
            kill_bus_q   <= kill_bus_d;
            ptr_q        <= ptr_d;
        end
    end

    uarc_event_fifo #(
        .WIDTH      ($bits(event_t)),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (ev_in),
        .pop       (event_ready),
        .head_data (ev_head),
        .valid     (event_valid),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Output fan-out from registers and the FIFO head.
    always_comb begin
        receiver_kill_acks   = kill_ack_q;
        receiver_incept_acks = incept_ack_q;
        receiver_send_acks   = send_ack_q;
        receiver_stream_acks = stream_ack_q;
        kill_out             = kill_out_q;
        kill_bus             = kill_bus_q;
        event_kind           = ev_head.kind;
        event_bus            = ev_head.bus;
        event_data           = ev_head.data;
        event_permission     = ev_head.permission;
        event_address        = ev_head.address;
    end

endmodule
